// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: push/status bus plus transmitter we/din/busy handshake for uart_tx_fifo
// Ports (signals):
//   wr_en, wr_data, flush, ovf_clr   bus-side push strobe, byte, queue discard, overflow clear
//   full, empty, level, overflow      bus-side status
//   tx_we, tx_din, tx_busy            transmitter start strobe, byte, busy
// slave is the FIFO; master is the surrounding system (bus plus transmitter), so it drives tx_busy.
interface uart_tx_fifo_if #(
    parameter int AW = 4
);
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          flush;
    logic          ovf_clr;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          overflow;
    logic          tx_we;
    logic [7:0]    tx_din;
    logic          tx_busy;
    modport master (
        output wr_en, wr_data, flush, ovf_clr, tx_busy,
        input  full, empty, level, overflow, tx_we, tx_din
    );
    modport slave (
        input  wr_en, wr_data, flush, ovf_clr, tx_busy,
        output full, empty, level, overflow, tx_we, tx_din
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that drains itself into a UART transmitter one byte at a time
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    uart_tx_fifo_if.slave: push/flush/ovf_clr in, full/empty/level/overflow out,
//          tx_we/tx_din out and tx_busy in towards the transmitter
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_fifo_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
    state_t        state_q, state_d;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    tx_din_q, tx_din_d;
    logic          full, empty, push, pop;

    assign full  = level_q == (AW+1)'(DEPTH);
    assign empty = level_q == '0;
    // full is the pre-edge value, so a pop in the same cycle never makes room for a push
    assign push  = bus.wr_en && !full && !bus.flush;
    // only the drain FSM pops, on its IDLE->ISSUE transition
    assign pop   = state_q == IDLE && !empty && !bus.tx_busy;

    always_comb begin
        rd_ptr_d   = bus.flush ? '0 : rd_ptr_q + AW'(pop);
        wr_ptr_d   = bus.flush ? '0 : wr_ptr_q + AW'(push);
        level_d    = bus.flush ? '0 : level_q + (AW+1)'(push) - (AW+1)'(pop);
        // setting wins over clearing
        overflow_d = (bus.wr_en && full) || (overflow_q && !bus.ovf_clr);
        tx_din_d   = pop ? mem[rd_ptr_q] : tx_din_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = pop ? ISSUE : IDLE;
            ISSUE:     state_d = WAIT_BUSY;
            // wait for the transmitter to acknowledge before watching for its end
            WAIT_BUSY: state_d = bus.tx_busy ? WAIT_DONE : WAIT_BUSY;
            WAIT_DONE: state_d = bus.tx_busy ? WAIT_DONE : IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.tx_we    = state_q == ISSUE;
        bus.tx_din   = tx_din_q;
        bus.full     = full;
        bus.empty    = empty;
        bus.level    = level_q;
        bus.overflow = overflow_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            tx_din_q   <= 8'h00;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            tx_din_q   <= tx_din_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) mem[wr_ptr_q] <= bus.wr_data;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo with a serial transmitter model and line decoder
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CPB   = 4;
    localparam int T     = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic t_busy = 1'b0;
    logic force_busy = 1'b0;
    logic line = 1'b1;
    logic blocked = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_we = 0;
    int   base;
    logic [7:0] exp_q[$];
    logic [7:0] line_exp[$];

    uart_tx_fifo_if #(.AW(AW)) bus ();
    uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #(T/2) clk = ~clk;
    assign bus.tx_busy = t_busy | force_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference FIFO: a byte is accepted unless the queue is known full (only knowable while draining is blocked)
    task automatic push(input logic [7:0] d);
        bus.wr_en = 1'b1;
        bus.wr_data = d;
        if (!(blocked && exp_q.size() >= DEPTH)) exp_q.push_back(d);
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic push_nb(input logic [7:0] d);
        int n = 0;
        while (bus.full !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("space_wait", 32'(n < 1000), 1);
        push(d);
    endtask

    task automatic wait_busy(input logic v, input string name);
        int n = 0;
        while (t_busy !== v && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(name, t_busy, v);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && line_exp.size() == 0 && t_busy == 1'b0 && bus.empty === 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < 3000), 1);
        repeat (4) @(negedge clk);
    endtask

    // Transmitter: samples tx_we at the edge, busy from the next cycle through the stop bit
    initial begin
        logic [9:0] f;
        forever begin
            @(negedge clk);
            if (bus.tx_we === 1'b1) begin
                f = {1'b1, bus.tx_din, 1'b0};
                @(posedge clk);
                #1 t_busy = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    line = f[i];
                    repeat (CPB) @(posedge clk);
                    #1;
                end
                t_busy = 1'b0;
            end
        end
    end

    // Line decoder: mid-bit sampling of 8N1 frames
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge line);
            #(CPB*T/2);
            chk("line_start", line, 0);
            for (int i = 0; i < 8; i++) begin
                #(CPB*T);
                b[i] = line;
            end
            #(CPB*T);
            chk("line_stop", line, 1);
            if (line_exp.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL line_unexpected: decoded %0h with nothing expected", b);
            end else chk("line_byte", b, line_exp.pop_front());
        end
    end

    // Monitor: every issued byte must be the oldest accepted one
    initial begin
        logic prev;
        logic [7:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) prev = 1'b0;
            else begin
                if (bus.tx_we === 1'b1) begin
                    n_we++;
                    chk("we_back_to_back", prev, 0);
                    chk("we_while_busy", bus.tx_busy, 0);
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_we: tx_din=%0h with nothing queued", bus.tx_din);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_din_order", bus.tx_din, e);
                        line_exp.push_back(e);
                    end
                end
                prev = bus.tx_we;
            end
        end
    end

    initial begin
        #(T*60000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.wr_en = 1'b0;
        bus.wr_data = 8'h00;
        bus.flush = 1'b0;
        bus.ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx_din", bus.tx_din, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            chk("idle_status", {bus.empty, bus.full, bus.level, bus.overflow, bus.tx_we}, {1'b1, 1'b0, 5'd0, 1'b0, 1'b0});
            @(negedge clk);
        end

        push(8'hA5);
        chk("lat_before", bus.tx_we, 0);
        @(negedge clk);
        chk("lat_we", bus.tx_we, 1);
        chk("lat_din", bus.tx_din, 8'hA5);
        wait_drain("single_drain");
        chk("single_empty", {bus.empty, bus.level}, {1'b1, 5'd0});

        base = n_we;
        for (int i = 0; i < 20; i++) push_nb(8'(i));
        wait_drain("burst_drain");
        chk("burst_count", n_we - base, 20);
        chk("burst_ovf", bus.overflow, 0);

        base = n_we;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            push_nb(8'($urandom));
        end
        wait_drain("rand_drain");
        chk("rand_count", n_we - base, 40);
        chk("rand_level", bus.level, 0);

        force_busy = 1'b1;
        blocked = 1'b1;
        for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
        chk("simul_pre_level", bus.level, 5);
        force_busy = 1'b0;
        push(8'hEE);
        chk("simul_level", bus.level, 5);
        chk("simul_we", bus.tx_we, 1);
        blocked = 1'b0;
        wait_drain("simul_drain");

        base = n_we;
        force_busy = 1'b1;
        blocked = 1'b1;
        for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
        chk("ovf_full16", {bus.full, bus.level, bus.overflow}, {1'b1, 5'd16, 1'b0});
        push(8'hFF);
        chk("ovf_set", {bus.full, bus.level, bus.overflow}, {1'b1, 5'd16, 1'b1});
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        chk("ovf_clr", bus.overflow, 0);
        bus.ovf_clr = 1'b1;
        push(8'hFE);
        bus.ovf_clr = 1'b0;
        chk("ovf_set_priority", {bus.overflow, bus.level}, {1'b1, 5'd16});
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        force_busy = 1'b0;
        blocked = 1'b0;
        wait_drain("ovf_drain");
        chk("ovf_count", n_we - base, 16);

        base = n_we;
        for (int i = 0; i < 8; i++) push(8'hC0 + 8'(i));
        wait_busy(1'b1, "flush_busy_wait");
        bus.flush = 1'b1;
        exp_q.delete();
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_level", {bus.level, bus.empty}, {5'd0, 1'b1});
        wait_drain("flush_drain");
        repeat (20) @(negedge clk);
        chk("flush_we_count", n_we - base, 1);

        base = n_we;
        for (int i = 0; i < 3; i++) push(8'hD0 + 8'(i));
        wait_busy(1'b1, "rst_busy_wait");
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid", {bus.tx_we, bus.level, bus.empty, bus.overflow}, {1'b0, 5'd0, 1'b1, 1'b0});
        wait_drain("rst_drain");
        repeat (20) @(negedge clk);
        chk("rst_we_count", n_we - base, 1);
        chk("line_all_decoded", line_exp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
